// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial sequence detector.
package seq_det_pkg;
  localparam int MAX_LEN_DEF = 8;
  localparam int GAP_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/seq_det_matcher.sv
// History shift register, fill counter and length-masked pattern comparator.
// Optional idle-gap flush of the history when SEQ_DET_GAP_FLUSH_EN is defined.
module seq_det_matcher
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic               din_valid_i,
  input  logic               din_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               overlap_i,
  output logic               match_o
);

  // Only MAX_LEN-1 past bits are ever compared; the newest bit is din itself.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] cand, mask;
  logic               gap_flush;

  always_comb begin
    cand = {hist_q, din_i};
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len_i);
  end

  assign match_o = en_i & din_valid_i & (fill_q >= (len_i - LEN_W'(1))) &
                   (((cand ^ pattern_i) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en_i && din_valid_i) begin
      hist_d = cand[MAX_LEN-2:0];
      if (match_o && !overlap_i)           fill_d = '0;
      else if (fill_q != LEN_W'(MAX_LEN))  fill_d = fill_q + LEN_W'(1);
    end else if (gap_flush) begin
      hist_d = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

`ifdef SEQ_DET_GAP_FLUSH_EN
  localparam int GAP_W = $clog2(GAP_TIMEOUT);
  logic [GAP_W-1:0] gap_q;

  // Counts consecutive idle RUN cycles; the last one of the window flushes.
  assign gap_flush = en_i & ~din_valid_i & (gap_q == GAP_W'(GAP_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr_i || !en_i || din_valid_i || gap_flush) gap_q <= '0;
    else                                                   gap_q <= gap_q + GAP_W'(1);
  end
`else
  assign gap_flush = 1'b0;
`endif

endmodule

// File: rtl/seq_det_ctrl.sv
// Serial sequence detector: configuration registers, IDLE/RUN/DONE FSM and
// saturating match counter. SEQ_DET_GAP_FLUSH_EN enables idle-gap history flush.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = MAX_LEN_DEF,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_wr,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               start,
  input  logic               stop,
  input  logic               din_valid,
  input  logic               din,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               thresh_hit,
  output logic               busy,
  output logic               cfg_err
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   thr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               cfg_err_q, cfg_err_d;
  logic               cfg_ld, clr, m_match, len_ok;

  assign len_ok = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr       = 1'b0;
    cfg_ld    = 1'b0;
    cfg_err_d = 1'b0;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (cfg_wr) begin
          if (len_ok) cfg_ld    = 1'b1;
          else        cfg_err_d = 1'b1;
        end
        if (start && !stop) begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end
      end
      ST_RUN: begin
        if (m_match) cnt_d = cnt_inc;
        // stop outranks the threshold transition
        if (stop) state_d = ST_IDLE;
        else if (m_match && (thr_q != '0) && (cnt_inc == thr_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (stop) state_d = ST_IDLE;
        else if (start) begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
      pat_q     <= '0;
      len_q     <= LEN_W'(2);
      ovl_q     <= 1'b1;
      thr_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
      if (cfg_ld) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        thr_q <= cfg_thresh;
      end
    end
  end

  seq_det_matcher #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_matcher (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .en_i       (state_q == ST_RUN),
    .din_valid_i(din_valid),
    .din_i      (din),
    .pattern_i  (pat_q),
    .len_i      (len_q),
    .overlap_i  (ovl_q),
    .match_o    (m_match)
  );

  assign match      = m_match;
  assign match_cnt  = cnt_q;
  assign thresh_hit = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus random traffic
// against a queue-based reference model of the detector.
module tb_seq_det_ctrl;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst, cfg_wr, cfg_overlap, start, stop, din_valid, din;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_thresh;
  logic               match, thresh_hit, busy, cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  always #5 clk = ~clk;

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
    .start(start), .stop(stop), .din_valid(din_valid), .din(din),
    .match(match), .match_cnt(match_cnt), .thresh_hit(thresh_hit),
    .busy(busy), .cfg_err(cfg_err)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state 0=idle 1=run 2=done; m_q holds usable received bits, oldest first.
  int                 m_st, m_len, m_thr, m_cnt, m_gap;
  bit [MAX_LEN-1:0]   m_pat;
  bit                 m_ovl, m_err, last_match;
  bit                 m_q[$];

  function automatic bit m_hit(input bit d);
    bit b;
    if (m_q.size() < m_len - 1) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      b = (k == 0) ? d : m_q[m_q.size() - k];
      if (b != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void m_clear();
    m_q.delete();
    m_gap = 0;
  endfunction

  function automatic void m_reset();
    m_st = 0; m_cnt = 0; m_err = 0;
    m_pat = '0; m_len = 2; m_ovl = 1; m_thr = 0;
    m_clear();
  endfunction

  // One clock: inputs are set at negedge; match checked before the edge, registers after.
  task automatic tick();
    bit em;
    #1;
    em = (m_st == 1) && din_valid && m_hit(din);
    last_match = match;
    chk("match", match, em);
    @(posedge clk);
    if (rst) m_reset();
    else begin
      m_err = 0;
      case (m_st)
        0: begin
          if (cfg_wr) begin
            if (cfg_len >= 2 && cfg_len <= MAX_LEN) begin
              m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap; m_thr = cfg_thresh;
            end else m_err = 1;
          end
          if (start && !stop) begin m_st = 1; m_cnt = 0; m_clear(); end
        end
        1: begin
          if (din_valid) begin
            m_q.push_back(din);
            if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
            m_gap = 0;
            if (em) begin
              if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
              if (!m_ovl) m_clear();
            end
          end else begin
`ifdef SEQ_DET_GAP_FLUSH_EN
            m_gap++;
            if (m_gap == 16) m_clear();
`endif
          end
          if (stop) m_st = 0;
          else if (em && m_thr != 0 && m_cnt == m_thr) m_st = 2;
        end
        default: begin
          if (stop) m_st = 0;
          else if (start) begin m_st = 1; m_cnt = 0; m_clear(); end
        end
      endcase
    end
    #1;
    chk("busy", busy, m_st != 0);
    chk("thresh_hit", thresh_hit, m_st == 2);
    chk("match_cnt", match_cnt, m_cnt);
    chk("cfg_err", cfg_err, m_err);
    @(negedge clk);
  endtask

  task automatic idle_in();
    rst = 0; cfg_wr = 0; start = 0; stop = 0; din_valid = 0; din = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic cfg(input logic [MAX_LEN-1:0] p, input int l, input bit o, input int t);
    cfg_wr = 1; cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o; cfg_thresh = CNT_W'(t);
    tick();
    cfg_wr = 0;
  endtask

  task automatic go();
    start = 1; tick(); start = 0;
  endtask

  task automatic halt();
    stop = 1; tick(); stop = 0;
  endtask

  // Feeds n bits MSB-first; h[i] records the match seen on the i-th bit.
  task automatic bits(input logic [15:0] v, input int n, output logic [15:0] h);
    h = '0;
    for (int i = 0; i < n; i++) begin
      din_valid = 1; din = v[n-1-i];
      tick();
      h[i] = last_match;
    end
    din_valid = 0; din = 0;
  endtask

  logic [15:0] h;

  initial begin
    idle_in();
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cfg_thresh = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_reset();
    tick();
    rst = 0;
    tick();

    // 101 overlapping
    cfg(8'b101, 3, 1, 0); go();
    bits(16'b10101, 5, h);
    chk("ovl_hits", h, 16'b10100);
    chk("ovl_cnt", match_cnt, 2);
    halt();

    // 101 non-overlapping
    cfg(8'b101, 3, 0, 0); go();
    bits(16'b10101, 5, h);
    chk("novl_hits", h, 16'b00100);
    chk("novl_cnt", match_cnt, 1);
    halt();

    // threshold 2 on pattern 11
    cfg(8'b11, 2, 1, 2); go();
    bits(16'b111, 3, h);
    chk("thr_hits", h, 16'b110);
    chk("thr_done", thresh_hit, 1);
    bits(16'b1111, 4, h);
    chk("done_nomatch", h, 0);
    chk("done_cnt", match_cnt, 2);

    // rejected / ignored configuration writes
    cfg(8'b0, 2, 1, 0);
    chk("cfg_busy_err", cfg_err, 0);
    halt();
    cfg(8'b0, 1, 1, 0);
    chk("cfg_len1_err", cfg_err, 1);
    cfg(8'b0, MAX_LEN + 1, 1, 0);
    chk("cfg_lenmax_err", cfg_err, 1);
    tick();
    chk("cfg_err_pulse", cfg_err, 0);
    go();
    cfg(8'b0, 2, 0, 0);
    bits(16'b111, 3, h);
    chk("cfg_kept_hits", h, 16'b110);
    chk("cfg_kept_done", thresh_hit, 1);

    // stop+start together from DONE and from RUN
    stop = 1; start = 1; tick(); stop = 0; start = 0;
    chk("ss_done_busy", busy, 0);
    go();
    stop = 1; start = 1; tick(); stop = 0; start = 0;
    chk("ss_run_busy", busy, 0);

    // stop coinciding with the threshold match
    cfg(8'b11, 2, 1, 1); go();
    bits(16'b1, 1, h);
    stop = 1; din_valid = 1; din = 1; tick(); stop = 0; din_valid = 0;
    chk("stopthr_match", last_match, 1);
    chk("stopthr_busy", busy, 0);
    chk("stopthr_hit", thresh_hit, 0);

    // reset in the middle of RUN
    cfg(8'b101, 3, 1, 0); go();
    bits(16'b10101, 5, h);
    rst = 1; tick(); rst = 0;
    chk("rst_cnt", match_cnt, 0);
    chk("rst_busy", busy, 0);

    // gap behaviour
    cfg(8'b101, 3, 1, 0);
`ifdef SEQ_DET_GAP_FLUSH_EN
    go(); bits(16'b10, 2, h); cyc(16); bits(16'b1, 1, h);
    chk("gap16_nomatch", h, 0);
    halt();
    go(); bits(16'b10, 2, h); cyc(15); bits(16'b1, 1, h);
    chk("gap15_match", h, 1);
    halt();
`else
    go(); bits(16'b10, 2, h); cyc(40); bits(16'b1, 1, h);
    chk("gap_retain", h, 1);
    halt();
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      rst         = (r == 0);
      cfg_wr      = (r >= 1 && r < 9);
      start       = (r >= 9 && r < 17);
      stop        = ($urandom_range(0, 99) < 3);
      din_valid   = ((i / 500) % 2 == 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
      din         = 1'($urandom);
      cfg_pattern = MAX_LEN'($urandom);
      cfg_len     = LEN_W'($urandom_range(0, 1) ? $urandom_range(1, 4) : $urandom_range(0, MAX_LEN + 2));
      cfg_overlap = 1'($urandom);
      cfg_thresh  = CNT_W'($urandom_range(0, 4));
      tick();
    end
    idle_in();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
